// File: rtl/event_blink_stretcher.sv
// Turns single-cycle event strobes into fixed-length LED blinks and queues
// events that arrive mid-blink. Optional macro EVENT_BLINK_OVF_EN adds a sticky overflow flag.
module event_blink_stretcher #(
    parameter int  SYSCLK_FREQ = 12000000,
    parameter real ON_TIME     = 0.100,
    parameter real OFF_TIME    = 0.100,
    parameter int  PEND_BITS   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pulse_in,
`ifdef EVENT_BLINK_OVF_EN
    input  logic                 ovf_clr,
    output logic                 ovf_flag,
`endif
    output logic                 led_out,
    output logic                 busy,
    output logic [PEND_BITS-1:0] pending
);

    localparam int ON_CYCLES  = $rtoi($floor(SYSCLK_FREQ * ON_TIME));
    localparam int OFF_CYCLES = $rtoi($floor(SYSCLK_FREQ * OFF_TIME));
    localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);

    // The timer counts down to zero, so a phase of N clocks loads N-1.
    localparam logic [TIMER_W-1:0]   ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0]   OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [PEND_BITS-1:0] PMAX     = {PEND_BITS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [PEND_BITS-1:0] pending_q, pending_d;
    logic                 led_q, led_d;
    logic                 busy_q, busy_d;
    logic                 final_off;
    logic                 pend_full;
    logic                 inc_req;

    assign final_off = (state_q == ST_OFF) && (timer_q == '0);
    assign pend_full = (pending_q == PMAX);
    // Events during a blink queue up, except on the last dark clock where they are consumed directly.
    assign inc_req   = pulse_in && (state_q != ST_IDLE) && !final_off;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        led_d     = led_q;
        busy_d    = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (pulse_in) begin
                    state_d = ST_ON;
                    timer_d = ON_LOAD;
                    led_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_ON: begin
                if (timer_q == '0) begin
                    state_d = ST_OFF;
                    timer_d = OFF_LOAD;
                    led_d   = 1'b0;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_OFF: begin
                if (final_off) begin
                    if ((pending_q != '0) || pulse_in) begin
                        state_d = ST_ON;
                        timer_d = ON_LOAD;
                        led_d   = 1'b1;
                        // A queued event and a fresh pulse cancel: one leaves, one arrives.
                        if ((pending_q != '0) && !pulse_in) begin
                            pending_d = pending_q - PEND_BITS'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                timer_d   = '0;
                pending_d = '0;
                led_d     = 1'b0;
                busy_d    = 1'b0;
            end
        endcase

        if (inc_req && !pend_full) begin
            pending_d = pending_q + PEND_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            pending_q <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
        end
    end

`ifdef EVENT_BLINK_OVF_EN
    logic ovf_q, ovf_d;

    // A drop on the same edge as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (inc_req && pend_full) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_flag = ovf_q;
`endif

    assign led_out = led_q;
    assign busy    = busy_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_event_blink_stretcher.sv
// Directed bench for event_blink_stretcher with 4 on / 3 off cycles and a 2-bit pending counter.
module tb_event_blink_stretcher;

  localparam int PEND_BITS = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 pulse_in;
  logic                 led_out;
  logic                 busy;
  logic [PEND_BITS-1:0] pending;
`ifdef EVENT_BLINK_OVF_EN
  logic                 ovf_clr;
  logic                 ovf_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  event_blink_stretcher #(
    .SYSCLK_FREQ(1000),
    .ON_TIME    (0.004),
    .OFF_TIME   (0.003),
    .PEND_BITS  (PEND_BITS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pulse_in(pulse_in),
`ifdef EVENT_BLINK_OVF_EN
    .ovf_clr (ovf_clr),
    .ovf_flag(ovf_flag),
`endif
    .led_out (led_out),
    .busy    (busy),
    .pending (pending)
  );

  // clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // advance past one rising edge; inputs are driven and outputs sampled 2 ns later
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic led_e, input logic busy_e, input int pend_e);
    check({tag, ".led"},  32'(led_out), 32'(led_e));
    check({tag, ".busy"}, 32'(busy),    32'(busy_e));
    check({tag, ".pend"}, 32'(pending), 32'(pend_e));
  endtask

  // n edges with pulse_in as currently driven, checking outputs after each
  task automatic expect_cycles(input string tag, input int n, input logic led_e, input logic busy_e, input int pend_e);
    for (int i = 0; i < n; i++) begin
      tick();
      check_outs(tag, led_e, busy_e, pend_e);
    end
  endtask

  // one full queued blink: 4 lit clocks then 3 dark clocks
  task automatic blink(input string tag, input int pend_e);
    expect_cycles({tag, ".on"},  4, 1'b1, 1'b1, pend_e);
    expect_cycles({tag, ".off"}, 3, 1'b0, 1'b1, pend_e);
  endtask

  task automatic single_pulse(input string tag);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    check_outs({tag, ".e0"}, 1'b1, 1'b1, 0);
    expect_cycles({tag, ".on"},  3, 1'b1, 1'b1, 0);
    expect_cycles({tag, ".off"}, 3, 1'b0, 1'b1, 0);
    expect_cycles({tag, ".end"}, 1, 1'b0, 1'b0, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    pulse_in = 1'b0;
`ifdef EVENT_BLINK_OVF_EN
    ovf_clr  = 1'b0;
`endif

    // reset state
    tick();
    tick();
    check_outs("reset", 1'b0, 1'b0, 0);
`ifdef EVENT_BLINK_OVF_EN
    check("reset.ovf", 32'(ovf_flag), 32'd0);
`endif
    rst_n = 1'b1;
    expect_cycles("idle0", 2, 1'b0, 1'b0, 0);

    // single pulse from idle
    single_pulse("single");
    expect_cycles("idle1", 2, 1'b0, 1'b0, 0);

    // three pulses during the first lit phase (edges E1, E3, E4)
    pulse_in = 1'b1;
    tick();
    check_outs("q3.e0", 1'b1, 1'b1, 0);
    tick();
    pulse_in = 1'b0;
    check_outs("q3.e1", 1'b1, 1'b1, 1);
    tick();
    check_outs("q3.e2", 1'b1, 1'b1, 1);
    pulse_in = 1'b1;
    tick();
    check_outs("q3.e3", 1'b1, 1'b1, 2);
    tick();
    pulse_in = 1'b0;
    check_outs("q3.e4", 1'b0, 1'b1, 3);
    expect_cycles("q3.off1", 2, 1'b0, 1'b1, 3);
    blink("q3.b2", 2);
    blink("q3.b3", 1);
    blink("q3.b4", 0);
    expect_cycles("q3.end", 1, 1'b0, 1'b0, 0);
    expect_cycles("idle2", 2, 1'b0, 1'b0, 0);

    // saturation: held through E0..E6, increments on E4..E6 are dropped
    pulse_in = 1'b1;
    tick();
    check_outs("sat.e0", 1'b1, 1'b1, 0);
    expect_cycles("sat.e1", 1, 1'b1, 1'b1, 1);
    expect_cycles("sat.e2", 1, 1'b1, 1'b1, 2);
    expect_cycles("sat.e3", 1, 1'b1, 1'b1, 3);
`ifdef EVENT_BLINK_OVF_EN
    check("sat.ovf_pre", 32'(ovf_flag), 32'd0);
`endif
    expect_cycles("sat.e4", 1, 1'b0, 1'b1, 3);
`ifdef EVENT_BLINK_OVF_EN
    check("sat.ovf_set", 32'(ovf_flag), 32'd1);
`endif
    expect_cycles("sat.e5", 2, 1'b0, 1'b1, 3);
    pulse_in = 1'b0;
    blink("sat.b2", 2);
`ifdef EVENT_BLINK_OVF_EN
    check("sat.ovf_sticky", 32'(ovf_flag), 32'd1);
    ovf_clr = 1'b1;
    expect_cycles("sat.b3.clr", 1, 1'b1, 1'b1, 1);
    ovf_clr = 1'b0;
    check("sat.ovf_clr", 32'(ovf_flag), 32'd0);
    expect_cycles("sat.b3.on", 3, 1'b1, 1'b1, 1);
    expect_cycles("sat.b3.off", 3, 1'b0, 1'b1, 1);
`else
    blink("sat.b3", 1);
`endif
    blink("sat.b4", 0);
    expect_cycles("sat.end", 1, 1'b0, 1'b0, 0);
    expect_cycles("idle3", 2, 1'b0, 1'b0, 0);

    // pulse on the final dark clock with nothing pending
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    check_outs("fin.e0", 1'b1, 1'b1, 0);
    expect_cycles("fin.on", 3, 1'b1, 1'b1, 0);
    expect_cycles("fin.off", 3, 1'b0, 1'b1, 0);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    check_outs("fin.e7", 1'b1, 1'b1, 0);
    expect_cycles("fin.on2", 3, 1'b1, 1'b1, 0);
    expect_cycles("fin.off2", 3, 1'b0, 1'b1, 0);
    expect_cycles("fin.end", 1, 1'b0, 1'b0, 0);
    expect_cycles("idle4", 2, 1'b0, 1'b0, 0);

    // asynchronous reset mid-lit with two pending
    pulse_in = 1'b1;
    tick();
    expect_cycles("rst.e1", 1, 1'b1, 1'b1, 1);
    tick();
    pulse_in = 1'b0;
    check_outs("rst.e2", 1'b1, 1'b1, 2);
    rst_n = 1'b0;
    #1;
    check_outs("rst.async", 1'b0, 1'b0, 0);
    tick();
    rst_n = 1'b1;
    expect_cycles("idle5", 2, 1'b0, 1'b0, 0);
    single_pulse("post_rst");
    expect_cycles("idle6", 2, 1'b0, 1'b0, 0);

    // pulse held three cycles from idle
    pulse_in = 1'b1;
    tick();
    check_outs("hold.e0", 1'b1, 1'b1, 0);
    expect_cycles("hold.e1", 1, 1'b1, 1'b1, 1);
    tick();
    pulse_in = 1'b0;
    check_outs("hold.e2", 1'b1, 1'b1, 2);
    expect_cycles("hold.e3", 1, 1'b1, 1'b1, 2);
    expect_cycles("hold.off1", 3, 1'b0, 1'b1, 2);
    blink("hold.b2", 1);
    blink("hold.b3", 0);
    expect_cycles("hold.end", 1, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
